carry_chain_serial_addsub: RTL and testbench

CARRY_CHAIN_SERIAL_ADDSUB -- requirements
Module: carry_chain_serial_addsub

---
 rtl/carry_chain_serial_addsub.sv | 150 +++++++++++++++
 tb/tb_carry_chain_serial_addsub.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/carry_chain_serial_addsub.sv
// Bit-serial (slice-serial) adder/subtractor: one INPUTS-bit slice per accepted
// beat, LSB slice first, with the carry and mode carried across slices.
module carry_chain_serial_addsub #(
  parameter int INPUTS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INPUTS-1:0] in_a,
  input  logic [INPUTS-1:0] in_b,
  input  logic              in_sub,
  input  logic              in_first,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INPUTS-1:0] out_s,
  output logic              out_last,
  output logic              out_co,
  output logic              out_ovf,
  output logic              err
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t              state_reg, state_next;
  logic                carry_reg, carry_next;
  logic                mode_reg, mode_next;
  logic                err_reg, err_next;
  logic                out_valid_reg, out_valid_next;
  logic [INPUTS-1:0]   out_s_reg, out_s_next;
  logic                out_last_reg, out_last_next;
  logic                out_co_reg, out_co_next;
  logic                out_ovf_reg, out_ovf_next;

  logic                accept;
  logic                produce;
  logic                sub_eff;
  logic [INPUTS-1:0]   bx;
  logic [INPUTS-1:0]   p;
  logic [INPUTS-1:0]   g;
  logic [INPUTS-1:0]   s;
  logic [INPUTS:0]     c;

  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;

  // A first slice always restarts the chain, whatever state we are in.
  assign sub_eff  = in_first ? in_sub : mode_reg;
  assign c[0]     = in_first ? in_sub : carry_reg;

  assign bx = in_b ^ {INPUTS{sub_eff}};
  assign p  = in_a ^ bx;
  assign g  = in_a & bx;

  generate
    for (genvar gi = 0; gi < INPUTS; gi++) begin : g_ripple
      assign c[gi+1] = p[gi] ? c[gi] : g[gi];
      assign s[gi]   = p[gi] ^ c[gi];
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    carry_next     = carry_reg;
    mode_next      = mode_reg;
    err_next       = err_reg;
    out_valid_next = out_valid_reg;
    out_s_next     = out_s_reg;
    out_last_next  = out_last_reg;
    out_co_next    = out_co_reg;
    out_ovf_next   = out_ovf_reg;
    produce        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (in_first) begin
            produce = 1'b1;
          end else begin
            // Orphan continuation slice: swallow it and flag the protocol error.
            err_next = 1'b1;
          end
        end
      end
      BUSY: begin
        if (accept) begin
          produce = 1'b1;
          if (in_first) begin
            err_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (produce) begin
      carry_next = c[INPUTS];
      mode_next  = sub_eff;
      state_next = in_last ? IDLE : BUSY;
    end

    if (in_ready) begin
      out_valid_next = produce;
      if (produce) begin
        out_s_next    = s;
        out_last_next = in_last;
        out_co_next   = c[INPUTS];
        out_ovf_next  = in_last ? (c[INPUTS] ^ c[INPUTS-1]) : 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      carry_reg     <= 1'b0;
      mode_reg      <= 1'b0;
      err_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      out_s_reg     <= '0;
      out_last_reg  <= 1'b0;
      out_co_reg    <= 1'b0;
      out_ovf_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      carry_reg     <= carry_next;
      mode_reg      <= mode_next;
      err_reg       <= err_next;
      out_valid_reg <= out_valid_next;
      out_s_reg     <= out_s_next;
      out_last_reg  <= out_last_next;
      out_co_reg    <= out_co_next;
      out_ovf_reg   <= out_ovf_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_s     = out_s_reg;
  assign out_last  = out_last_reg;
  assign out_co    = out_co_reg;
  assign out_ovf   = out_ovf_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_carry_chain_serial_addsub.sv
// Bench for carry_chain_serial_addsub: directed vector table, hand-written
// corner sequences, then random 16-bit add/sub against an arithmetic model.
module tb_carry_chain_serial_addsub;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_sub = 1'b0;
  logic         in_first = 1'b0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_s;
  logic         out_last;
  logic         out_co;
  logic         out_ovf;
  logic         err;

  int checks = 0;
  int errors = 0;

  carry_chain_serial_addsub #(.INPUTS(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_s(out_s), .out_last(out_last), .out_co(out_co), .out_ovf(out_ovf),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       sub;
    logic       first;
    logic       last;
    logic [3:0] s;
    logic       co;
    logic       lst;
    logic       ovf;
  } vec_t;

  typedef struct {
    logic [3:0] s;
    logic       co;
    logic       lst;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  bit   sb_en = 0;
  bit   rand_bp = 0;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic sub,
                       input logic first, input logic last);
    in_a = a; in_b = b; in_sub = sub; in_first = first; in_last = last;
    in_valid = 1'b1;
  endtask

  // Present one slice and return #1 after the edge where it was accepted.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic sub,
                      input logic first, input logic last);
    bit acc;
    int n;
    drive(a, b, sub, first, last);
    acc = 0;
    n = 0;
    while (!acc && n < 1000) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      n++;
    end
    #1;
    in_valid = 1'b0;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: in_ready never high, required 1");
    end
  endtask

  task automatic check_out(input string name, input logic [3:0] s, input logic co,
                           input logic lst, input logic ovf);
    check({name, "_valid"}, int'(out_valid), 1);
    check({name, "_s_co_last_ovf"}, int'({out_s, out_co, out_last, out_ovf}),
          int'({s, co, lst, ovf}));
  endtask

  // Scoreboard monitor and stall-stability check, active in the random phase.
  logic [6:0] held;
  bit         held_ok = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (sb_en && rst_n) begin
        if (out_valid && held_ok)
          check("stall_stable", int'({out_s, out_co, out_last, out_ovf}), int'(held));
        held_ok = out_valid && !out_ready;
        held = {out_s, out_co, out_last, out_ovf};
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: slice s=%0h with empty queue", out_s);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("sb_slice", int'({out_s, out_co, out_last, out_ovf}),
                  int'({e.s, e.co, e.lst, e.ovf}));
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_bp) out_ready = ($urandom_range(0, 9) < 7);
    end
  end

  vec_t vecs[8];

  initial begin
    vecs[0] = '{4'hF, 4'h1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{4'h3, 4'h5, 1'b1, 1'b1, 1'b1, 4'hE, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{4'h8, 4'h1, 1'b1, 1'b1, 1'b1, 4'h7, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{4'h7, 4'h1, 1'b0, 1'b1, 1'b1, 4'h8, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{4'hF, 4'hF, 1'b0, 1'b1, 1'b1, 4'hE, 1'b1, 1'b1, 1'b0};
    // 0x10 - 0x01 with in_sub deasserted on the second slice: mode must be latched.
    vecs[6] = '{4'h0, 4'h1, 1'b1, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{4'h1, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0};

    // Reset state
    #12;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_err", int'(err), 0);
    check("rst_outs", int'({out_s, out_co, out_last, out_ovf}), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].first, vecs[i].last);
      check_out($sformatf("vec%0d", i), vecs[i].s, vecs[i].co, vecs[i].lst, vecs[i].ovf);
    end
    check("vec_err", int'(err), 0);

    // Backpressure: 0x5A + 0x3C = 0x96 with the first result held 3 cycles.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(4'hA, 4'hC, 1'b0, 1'b1, 1'b0);
    check_out("bp_first", 4'h6, 1'b1, 1'b0, 1'b0);
    drive(4'h5, 4'h3, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp_in_ready", int'(in_ready), 0);
      check_out("bp_hold", 4'h6, 1'b1, 1'b0, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_out("bp_second", 4'h9, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check("bp_drained", int'(out_valid), 0);

    // Protocol errors
    send(4'h3, 4'h3, 1'b0, 1'b0, 1'b0);
    check("perr_drop_valid", int'(out_valid), 0);
    check("perr_drop_err", int'(err), 1);
    send(4'h1, 4'h1, 1'b0, 1'b1, 1'b0);
    check_out("perr_op1", 4'h2, 1'b0, 1'b0, 1'b0);
    send(4'hF, 4'h1, 1'b0, 1'b1, 1'b0);
    check_out("perr_restart", 4'h0, 1'b1, 1'b0, 1'b0);
    send(4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    check_out("perr_restart_last", 4'h1, 1'b0, 1'b1, 1'b0);
    check("perr_err_sticky", int'(err), 1);

    // Reset mid-operation after slice 1 of 3
    send(4'h5, 4'h5, 1'b1, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_valid", int'(out_valid), 0);
    check("mrst_err", int'(err), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(4'hF, 4'h1, 1'b0, 1'b1, 1'b0);
    check_out("mrst_lo", 4'h0, 1'b1, 1'b0, 1'b0);
    send(4'h7, 4'h0, 1'b0, 1'b0, 1'b1);
    check_out("mrst_hi", 4'h8, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #1;

    // Random 16-bit operations with random stalls
    sb_en = 1;
    rand_bp = 1;
    for (int op = 0; op < 200; op++) begin
      int a, b, bx, sub, r, low, mask;
      exp_t e;
      a = int'($urandom_range(0, 65535));
      b = int'($urandom_range(0, 65535));
      sub = int'($urandom_range(0, 1));
      bx = sub != 0 ? (~b & 16'hFFFF) : b;
      r = (a + bx + sub) & 16'hFFFF;
      for (int k = 0; k < 4; k++) begin
        mask = (1 << (4 * k + 4)) - 1;
        low = (a & mask) + (bx & mask) + sub;
        e.s = 4'((low >> (4 * k)) & 15);
        e.co = 1'((low >> (4 * k + 4)) & 1);
        e.lst = (k == 3);
        if (k == 3) begin
          if (sub != 0)
            e.ovf = (a[15] != b[15]) && (r[15] != a[15]);
          else
            e.ovf = (a[15] == b[15]) && (r[15] != a[15]);
        end else begin
          e.ovf = 1'b0;
        end
        exp_q.push_back(e);
        repeat ($urandom_range(0, 3) == 0 ? 1 : 0) begin
          @(posedge clk);
          #1;
        end
        send(4'((a >> (4 * k)) & 15), 4'((b >> (4 * k)) & 15),
             (k == 0) ? 1'(sub) : 1'($urandom_range(0, 1)), k == 0, k == 3);
      end
    end
    rand_bp = 0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("sb_drain", exp_q.size(), 0);
    check("rand_err", int'(err), 0);
    sb_en = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
